// File: rtl/sram_bist_pkg.sv
// sram_bist shared types: FSM encoding, march element ids,
// SRAM op kinds and default widths.
package sram_bist_pkg;

  localparam int BW_DATA_D = 64;
  localparam int BW_ADDR_D = 6;
  localparam int BW_ERR_D  = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_M0   = 3'd1;
  localparam logic [2:0] ST_M1   = 3'd2;
  localparam logic [2:0] ST_M2   = 3'd3;
  localparam logic [2:0] ST_M3   = 3'd4;
  localparam logic [2:0] ST_M4   = 3'd5;
  localparam logic [2:0] ST_M5   = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  typedef enum logic [2:0] {
    EL_NONE = 3'd0,
    EL_M1   = 3'd1,
    EL_M2   = 3'd2,
    EL_M3   = 3'd3,
    EL_M4   = 3'd4,
    EL_M5   = 3'd5
  } elem_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  function automatic elem_e st2elem(
    input logic [2:0] st
  );
    elem_e e;
    e = EL_NONE;
    case (st)
      ST_M1:   e = EL_M1;
      ST_M2:   e = EL_M2;
      ST_M3:   e = EL_M3;
      ST_M4:   e = EL_M4;
      ST_M5:   e = EL_M5;
      default: e = EL_NONE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-data checker: compares each read one cycle later and
// keeps sticky fail, first-fail location and saturating count.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_D,
  parameter int BW_ADDR = BW_ADDR_D,
  parameter int BW_ERR  = BW_ERR_D
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_rd_vld,
  input  logic [BW_DATA-1:0] i_exp,
  input  logic [BW_ADDR-1:0] i_addr,
  input  elem_e              i_elem,
  input  logic [BW_DATA-1:0] i_rdata,
  output logic               o_fail,
  output logic [BW_ADDR-1:0] o_fail_addr,
  output logic [2:0]         o_fail_elem,
  output logic [BW_ERR-1:0]  o_err_cnt
);

  logic               r_vld;
  logic [BW_DATA-1:0] r_exp;
  logic [BW_ADDR-1:0] r_addr;
  elem_e              r_elem;
  logic               r_fail;
  logic [BW_ADDR-1:0] r_fail_addr;
  logic [2:0]         r_fail_elem;
  logic [BW_ERR-1:0]  r_err_cnt;
  logic               w_mis;
  logic               w_sat;

  // SRAM returns data the cycle after the read strobe
  assign w_mis = r_vld && (i_rdata != r_exp);
  assign w_sat = &r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_vld       <= 1'b0;
      r_exp       <= '0;
      r_addr      <= '0;
      r_elem      <= EL_NONE;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_vld  <= i_rd_vld;
      r_exp  <= i_exp;
      r_addr <= i_addr;
      r_elem <= i_elem;
      if (w_mis) begin
        r_fail <= 1'b1;
        if (!w_sat) r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail) begin
          r_fail_addr <= r_addr;
          r_fail_elem <= r_elem;
        end
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: rtl/sram_bist.sv
// March C- BIST initiator for a single-port SRAM: sequences
// the elements and drives registered SRAM strobes.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_D,
  parameter int BW_ADDR = BW_ADDR_D,
  parameter int BW_ERR  = BW_ERR_D
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_bg,
  output logic [BW_ADDR-1:0] o_sram_addr,
  output logic [BW_DATA-1:0] o_sram_data,
  output logic               o_sram_wen,
  output logic               o_sram_oen,
  input  logic [BW_DATA-1:0] i_sram_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fail,
  output logic [BW_ADDR-1:0] o_fail_addr,
  output logic [2:0]         o_fail_elem,
  output logic [BW_ERR-1:0]  o_err_cnt
);

  localparam logic [BW_ADDR-1:0] A_LAST = '1;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nx;
  logic [BW_ADDR-1:0] r_addr;
  logic [BW_ADDR-1:0] w_addr_nx;
  logic               r_ph;
  logic               w_ph_nx;
  logic [BW_DATA-1:0] r_bg;
  logic [BW_DATA-1:0] w_bg;
  logic [BW_DATA-1:0] w_pat;
  logic               w_start;
  logic               w_last;
  logic               w_zero;
  logic               w_vld;
  logic               w_one;
  op_e                w_op;
  logic               w_rd;
  logic               w_wr;
  logic               r_wen;
  logic               r_oen;
  logic [BW_ADDR-1:0] r_sram_addr;
  logic [BW_DATA-1:0] r_sram_data;
  logic [BW_DATA-1:0] r_exp;
  elem_e              r_elem;

  assign w_start = i_start &&
    (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_bg   = w_start ? i_bg : r_bg;
  assign w_last = (r_addr == A_LAST);
  assign w_zero = (r_addr == '0);

  // r_ph: 0 = read slot, 1 = write slot (M5: final compare)
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_ph_nx    = r_ph;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) begin
          w_state_nx = ST_M0;
          w_addr_nx  = '0;
          w_ph_nx    = 1'b0;
        end
      end
      ST_M0: begin
        if (w_last) begin
          w_state_nx = ST_M1;
          w_addr_nx  = '0;
        end else begin
          w_addr_nx = r_addr + 1'b1;
        end
      end
      ST_M1, ST_M2: begin
        w_ph_nx = ~r_ph;
        if (r_ph) begin
          if (w_last) begin
            w_state_nx = r_state + 3'd1;
            w_addr_nx  = (r_state == ST_M2) ? A_LAST : '0;
          end else begin
            w_addr_nx = r_addr + 1'b1;
          end
        end
      end
      ST_M3, ST_M4: begin
        w_ph_nx = ~r_ph;
        if (r_ph) begin
          if (w_zero) begin
            w_state_nx = r_state + 3'd1;
            w_addr_nx  = A_LAST;
          end else begin
            w_addr_nx = r_addr - 1'b1;
          end
        end
      end
      ST_M5: begin
        if (r_ph)        w_state_nx = ST_DONE;
        else if (w_zero) w_ph_nx    = 1'b1;
        else             w_addr_nx  = r_addr - 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_vld = 1'b1;
    w_op  = OP_WR;
    w_one = 1'b0;
    unique case (w_state_nx)
      ST_M0: begin
        w_op = OP_WR;
      end
      ST_M1, ST_M3: begin
        w_op  = w_ph_nx ? OP_WR : OP_RD;
        w_one = w_ph_nx;
      end
      ST_M2, ST_M4: begin
        w_op  = w_ph_nx ? OP_WR : OP_RD;
        w_one = ~w_ph_nx;
      end
      ST_M5: begin
        w_op  = OP_RD;
        w_vld = ~w_ph_nx;
      end
      default: w_vld = 1'b0;
    endcase
  end

  assign w_pat = w_one ? ~w_bg : w_bg;
  assign w_rd  = w_vld && (w_op == OP_RD);
  assign w_wr  = w_vld && (w_op == OP_WR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_ph        <= 1'b0;
      r_bg        <= '0;
      r_wen       <= 1'b1;
      r_oen       <= 1'b1;
      r_sram_addr <= '0;
      r_sram_data <= '0;
      r_exp       <= '0;
      r_elem      <= EL_NONE;
    end else begin
      r_state     <= w_state_nx;
      r_addr      <= w_addr_nx;
      r_ph        <= w_ph_nx;
      if (w_start) r_bg <= i_bg;
      r_wen       <= ~w_wr;
      r_oen       <= ~w_rd;
      r_sram_addr <= w_vld ? w_addr_nx : '0;
      r_sram_data <= w_wr ? w_pat : '0;
      r_exp       <= w_rd ? w_pat : '0;
      r_elem      <= w_rd ? st2elem(w_state_nx) : EL_NONE;
    end
  end

  assign o_sram_addr = r_sram_addr;
  assign o_sram_data = r_sram_data;
  assign o_sram_wen  = r_wen;
  assign o_sram_oen  = r_oen;
  assign o_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done = (r_state == ST_DONE);

  sram_bist_cmp #(
    .BW_DATA (BW_DATA),
    .BW_ADDR (BW_ADDR),
    .BW_ERR  (BW_ERR)
  ) u_cmp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_start),
    .i_rd_vld    (~r_oen),
    .i_exp       (r_exp),
    .i_addr      (r_sram_addr),
    .i_elem      (r_elem),
    .i_rdata     (i_sram_data),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_fail_elem (o_fail_elem),
    .o_err_cnt   (o_err_cnt)
  );

endmodule

// File: tb/tb_sram_bist.sv
// sram_bist bench: SRAM model with injectable faults and a
// queue of expected pin cycles for each March C- run.
module tb_sram_bist;

  localparam int BD = 64;
  localparam int BA = 6;
  localparam int BE = 8;
  localparam int N  = 64;
  localparam int LEN = 10 * N + 1;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [BD-1:0] i_bg;
  logic [BA-1:0] o_sram_addr;
  logic [BD-1:0] o_sram_data;
  logic          o_sram_wen;
  logic          o_sram_oen;
  logic [BD-1:0] i_sram_data;
  logic          o_busy;
  logic          o_done;
  logic          o_fail;
  logic [BA-1:0] o_fail_addr;
  logic [2:0]    o_fail_elem;
  logic [BE-1:0] o_err_cnt;

  logic [BD-1:0] mem [N];
  int            fault;
  logic [71:0]   q [$];
  int            n_cmp;
  int            n_bad;

  always #5 clk = ~clk;

  sram_bist #(
    .BW_DATA (BD),
    .BW_ADDR (BA),
    .BW_ERR  (BE)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_bg        (i_bg),
    .o_sram_addr (o_sram_addr),
    .o_sram_data (o_sram_data),
    .o_sram_wen  (o_sram_wen),
    .o_sram_oen  (o_sram_oen),
    .i_sram_data (i_sram_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_fail_elem (o_fail_elem),
    .o_err_cnt   (o_err_cnt)
  );

  // fault 1: bit 0 of word 5 stuck at 0; fault 2: reads inverted
  always @(posedge clk) begin
    if (!o_sram_wen) begin
      if (fault == 1 && o_sram_addr == 6'd5)
        mem[o_sram_addr] <= {o_sram_data[BD-1:1], 1'b0};
      else
        mem[o_sram_addr] <= o_sram_data;
    end
    if (!o_sram_oen) begin
      if (fault == 2) i_sram_data <= ~mem[o_sram_addr];
      else            i_sram_data <= mem[o_sram_addr];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [71:0] got,
    input logic [71:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [BD-1:0] bg);
    logic [BA-1:0] a;
    logic [BD-1:0] wd;
    for (int k = 0; k < N; k++) begin
      a = BA'(k);
      q.push_back({1'b0, 1'b1, a, bg});
    end
    for (int e = 1; e <= 4; e++) begin
      wd = (e % 2 == 1) ? ~bg : bg;
      for (int k = 0; k < N; k++) begin
        a = (e <= 2) ? BA'(k) : BA'(N - 1 - k);
        q.push_back({1'b1, 1'b0, a, {BD{1'b0}}});
        q.push_back({1'b0, 1'b1, a, wd});
      end
    end
    for (int k = 0; k < N; k++) begin
      a = BA'(N - 1 - k);
      q.push_back({1'b1, 1'b0, a, {BD{1'b0}}});
    end
    q.push_back({1'b1, 1'b1, {BA{1'b0}}, {BD{1'b0}}});
  endtask

  function automatic logic [71:0] pins();
    return {o_sram_wen, o_sram_oen, o_sram_addr, o_sram_data};
  endfunction

  task automatic run(
    input logic [BD-1:0] bg,
    input int            flt,
    input int            pulse_at,
    input int            rst_at
  );
    fault = flt;
    q.delete();
    push_exp(bg);
    i_bg    = bg;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_bg    = ~bg;
    for (int c = 1; c <= LEN; c++) begin
      i_start = (c == pulse_at);
      if (c == 1 || c == LEN) chk("busy", 72'(o_busy), 72'(1));
      if (c == LEN) chk("done_early", 72'(o_done), 72'(0));
      if (q.size() > 0) chk("pins", pins(), q.pop_front());
      else chk("queue_empty", 72'(q.size()), 72'(1));
      if (c == rst_at) begin
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("rst_pins", pins(), {2'b11, 70'd0});
        chk("rst_busy", 72'(o_busy), 72'(0));
        chk("rst_done", 72'(o_done), 72'(0));
        chk("rst_err", 72'(o_err_cnt), 72'(0));
        chk("rst_fail", 72'(o_fail), 72'(0));
        return;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    chk("busy_end", 72'(o_busy), 72'(0));
    chk("done", 72'(o_done), 72'(1));
    chk("pins_done", pins(), {2'b11, 70'd0});
  endtask

  task automatic chk_stat(
    input logic          fail,
    input logic [BA-1:0] fa,
    input logic [2:0]    fe,
    input logic [BE-1:0] ec
  );
    chk("fail", 72'(o_fail), 72'(fail));
    chk("fail_addr", 72'(o_fail_addr), 72'(fa));
    chk("fail_elem", 72'(o_fail_elem), 72'(fe));
    chk("err_cnt", 72'(o_err_cnt), 72'(ec));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    fault   = 0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_bg    = '0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("reset_pins", pins(), {2'b11, 70'd0});
    chk("reset_busy", 72'(o_busy), 72'(0));
    chk("reset_done", 72'(o_done), 72'(0));
    chk_stat(1'b0, 6'd0, 3'd0, 8'd0);
    @(posedge clk); #1;

    run('0, 0, 0, 0);
    chk_stat(1'b0, 6'd0, 3'd0, 8'd0);

    run('0, 1, 0, 0);
    chk_stat(1'b1, 6'd5, 3'd2, 8'd2);

    run({16{4'hA, 4'h5}}, 2, 0, 0);
    chk_stat(1'b1, 6'd0, 3'd1, 8'd255);

    run({$urandom, $urandom}, 0, 100, 0);
    chk_stat(1'b0, 6'd0, 3'd0, 8'd0);

    run({$urandom, $urandom}, 0, 0, 300);
    @(posedge clk); #1;
    run(64'h0123_4567_89AB_CDEF, 0, 0, 0);
    chk_stat(1'b0, 6'd0, 3'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- March C- built-in self-test initiator for the 64-bit × 64-entry extended single-port SRAM.
- Drives the SRAM's address, write-data, write-enable and output-enable pins, and samples its read data.
- Compares every read against the expected pattern and reports pass/fail, first-failure location and error count.
- Sits between the test/debug controller (start/status) and the SRAM array.

Parameters:
BW_DATA, 64, SRAM data width
BW_ADDR, 6, SRAM address width; N = 2**BW_ADDR words
BW_ERR, 8, error counter width (saturating)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_start  in  1  start pulse; honoured only when idle
i_bg  in  BW_DATA  data background; "0" = i_bg, "1" = ~i_bg; captured at start
o_sram_addr  out  BW_ADDR  SRAM address
o_sram_data  out  BW_DATA  SRAM write data
o_sram_wen  out  1  SRAM write enable, active-low
o_sram_oen  out  1  SRAM output enable, active-low
i_sram_data  in  BW_DATA  SRAM read data, valid the cycle after a read cycle
o_busy  out  1  test running
o_done  out  1  test finished; sticky until next accepted start
o_fail  out  1  at least one mismatch; sticky until next accepted start
o_fail_addr  out  BW_ADDR  address of first mismatch
o_fail_elem  out  3  march element (1..5) of first mismatch
o_err_cnt  out  BW_ERR  total mismatches, saturating

Behaviour:
- Reset: all outputs 0, except o_sram_wen=1 and o_sram_oen=1. State IDLE.
- SRAM strobes are registered outputs. A read cycle is oen=0, wen=1. A write cycle is wen=0, oen=1. Idle is wen=1, oen=1, addr=0, data=0.
- States: IDLE, M0..M5, DONE.
  - M0 ⇑ w0: one write per address, 0..N-1.
  - M1 ⇑ r0,w1 / M2 ⇑ r1,w0: per address, a read cycle then a write cycle, addresses 0..N-1.
  - M3 ⇓ r0,w1 / M4 ⇓ r1,w0: as above, addresses N-1..0.
  - M5 ⇓ r0: one read per address, N-1..0, then one extra compare cycle before DONE.
- Start:
  - i_start=1 in IDLE or DONE at edge t: capture i_bg; clear o_done, o_fail, o_err_cnt, o_fail_addr, o_fail_elem; enter M0.
  - First write appears on the pins in cycle t+1. o_busy=1 from t+1.
- Total length: N + 4·2N + N + 1 = 10N+1 cycles (641 for N=64).
- Finish: at the end of the last compare cycle enter DONE. o_busy=0 and o_done=1 in the same cycle.
- Compare:
  - Expected value for each read is registered alongside the read cycle.
  - Comparison happens the following cycle against i_sram_data. For M1–M4 this is the paired write cycle; for M5 it is the next read or the final compare cycle.
- Mismatch:
  - o_fail←1.
  - o_err_cnt increments, holding at 2**BW_ERR-1.
  - If this is the first mismatch since start, latch the read's address and element number.
- i_start while busy: ignored.
- i_start held high in DONE: restarts.
- Address counters wrap at element boundaries only. Reaching the final address terminates the element; no wrap-around writes.
- Reset mid-run: at that edge return to IDLE, strobes idle, all status cleared. No partial write beyond the cycle already issued.

Decomposition:
- Package sram_bist_pkg:
  - state encoding (IDLE, M0..M5, DONE)
  - element ids
  - op type {RD, WR}
  - default widths
- One sub-module sram_bist_cmp: takes expected data, read-valid, address and element. Holds o_fail, first-fail capture and the saturating o_err_cnt.
- The FSM and address/phase counters stay in sram_bist.

Test Plan:
- Fault-free memory model, i_bg=0, start pulse at cycle 0:
  - o_busy rises at cycle 1; o_done=1 at cycle 642.
  - o_fail=0, o_err_cnt=0.
  - Check 64 writes of 64'h0 to addr 0..63 in cycles 1–64.
  - Cycle 65: read addr 0 (oen=0). Cycle 66: write addr 0 with all-ones (wen=0).
- Stuck-at-0 on bit 0 of addr 5, i_bg=0:
  - o_fail=1, o_fail_addr=5, o_fail_elem=2, o_err_cnt=2 (one in M2, one in M4).
- Memory that inverts every read, i_bg=64'hA5A5…:
  - All 320 reads fail; o_err_cnt saturates at 255.
  - o_fail_addr=0, o_fail_elem=1.
- i_start pulsed at cycle 100 mid-run:
  - Ignored; o_done still at cycle 642; pin sequence identical to the fault-free run.
- i_rst asserted at cycle 300:
  - Cycle 301: wen=1, oen=1, o_busy=0, o_done=0, o_err_cnt=0.
  - A new start then completes normally in 641 cycles.
- Back-to-back runs: the second run (fault-free) clears the sticky o_fail and fail info from a failing first run, with i_start asserted in DONE.
